// File: rtl/nbit_cla_full_adder_pkg.sv
// Shared definitions for the carry-lookahead adder slice.
// GROUP_W     : width of one first-level lookahead group.
// group_count : number of groups needed to cover an n-bit operand.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned group_count(input int unsigned n);
    return (n + GROUP_W - 1) / GROUP_W;
  endfunction

endpackage

// File: rtl/nbit_cla_full_adder_if.sv
// Operand/result bundle for nbit_cla_full_adder.
//   a, b : N-bit unsigned operands (driven by master)
//   sum  : N+1-bit registered result {carry_out, a+b} (driven by slave)
interface nbit_cla_full_adder_if #(
  parameter int unsigned N = 64
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   sum;

  modport master (output a, output b, input sum);
  modport slave  (input a, input b, output sum);
endinterface

// File: rtl/nbit_cla_full_adder_group4.sv
// First-level 4-bit carry-lookahead group.
//   i_g, i_p : per-bit generate / propagate
//   i_cin    : carry into bit 0 of the group
//   o_c      : carry into each bit of the group (o_c[0] == i_cin)
//   o_g, o_p : group generate / propagate (independent of i_cin)
module cla_group4 (
  input  logic [3:0] i_g,
  input  logic [3:0] i_p,
  input  logic       i_cin,
  output logic [3:0] o_c,
  output logic       o_g,
  output logic       o_p
);

  assign o_c[0] = i_cin;
  assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);

  assign o_g = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
             | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_p = &i_p;

endmodule

// File: rtl/nbit_cla_full_adder.sv
// N-bit unsigned two-level carry-lookahead adder with registered result.
//   clk   : clock, result updates on rising edge
//   rst_n : asynchronous active-low reset, clears sum
//   bus   : slave side of nbit_cla_full_adder_if (a, b in; sum out)
// sum = {carry_out, a+b}, one cycle latency, carry-in fixed at 0.
module nbit_cla_full_adder
  import cla_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nbit_cla_full_adder_if.slave   bus
);

  localparam int unsigned NG = group_count(N);
  localparam int unsigned NP = NG * GROUP_W;

  logic [NP-1:0] w_a_ext;
  logic [NP-1:0] w_b_ext;
  logic [NP-1:0] w_g;
  logic [NP-1:0] w_p;
  logic [NP-1:0] w_c;
  logic [NG-1:0] w_gg;
  logic [NG-1:0] w_gp;
  logic [NG:0]   w_gc;
  logic [NP:0]   w_carry;
  logic [N:0]    w_sum_next;
  logic          w_unused_pad;
  logic [N:0]    r_sum;

  // Zero-extend to whole groups; pad lanes generate nothing and are dropped.
  always_comb begin
    w_a_ext = '0;
    w_b_ext = '0;
    w_a_ext[N-1:0] = bus.a;
    w_b_ext[N-1:0] = bus.b;
  end

  assign w_g = w_a_ext & w_b_ext;
  assign w_p = w_a_ext ^ w_b_ext;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .i_g   (w_g[gi*GROUP_W +: GROUP_W]),
      .i_p   (w_p[gi*GROUP_W +: GROUP_W]),
      .i_cin (w_gc[gi]),
      .o_c   (w_c[gi*GROUP_W +: GROUP_W]),
      .o_g   (w_gg[gi]),
      .o_p   (w_gp[gi])
    );
  end

  // Second level: carry into group j is the OR over earlier groups k of
  // G[k] propagated through P[k+1..j-1]; each term is a flat AND, no ripple.
  always_comb begin
    logic v_term;
    v_term = 1'b0;
    w_gc   = '0;
    for (int unsigned j = 1; j <= NG; j++) begin
      for (int unsigned k = 0; k < j; k++) begin
        v_term = w_gg[k];
        for (int unsigned m = k + 1; m < j; m++) begin
          v_term = v_term & w_gp[m];
        end
        w_gc[j] = w_gc[j] | v_term;
      end
    end
  end

  // Carry into bit N equals the carry out of bit N-1 (pad bits are zero).
  assign w_carry    = {w_gc[NG], w_c};
  assign w_sum_next = {w_carry[N], w_p[N-1:0] ^ w_c[N-1:0]};

  // Pad-lane and group-0 propagate bits are structurally unused.
  assign w_unused_pad = ^{w_carry, w_p, w_gp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum_next;
    end
  end

  assign bus.sum = r_sum;

endmodule

// File: tb/tb_nbit_cla_full_adder.sv
module tb_nbit_cla_full_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  nbit_cla_full_adder_if #(.N(64)) if64 ();
  nbit_cla_full_adder_if #(.N(8))  if8  ();
  nbit_cla_full_adder_if #(.N(6))  if6  ();

  nbit_cla_full_adder #(.N(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
  nbit_cla_full_adder #(.N(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  nbit_cla_full_adder #(.N(6))  u_dut6  (.clk(clk), .rst_n(rst_n), .bus(if6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ra;
    logic [5:0] rb;
    logic [6:0] rexp;
    checks   = 0;
    failures = 0;

    // Reset held with all-ones operands and a running clock.
    rst_n = 1'b0;
    if64.a = '1; if64.b = '1;
    if8.a  = '1; if8.b  = '1;
    if6.a  = '1; if6.b  = '1;
    tick(); tick(); tick();
    check("rst_hold_64", if64.sum, 129'h0);
    check("rst_hold_8",  if8.sum,  129'h0);
    check("rst_hold_6",  if6.sum,  129'h0);

    // Release reset between edges; first edge loads the first vector.
    if64.a = 64'h00000F8010000700; if64.b = 64'h004002C0C200FC00;
    if8.a  = 8'h0A;               if8.b  = 8'h71;
    if6.a  = 6'h3F;               if6.b  = 6'h01;
    #4 rst_n = 1'b1;
    tick();
    check("v64_carry15",  if64.sum, 129'h0_00401240D2010300);
    check("v8_0a_71",     if8.sum,  129'h07B);
    check("v6_3f_01",     if6.sum,  129'h40);

    if64.a = 64'h06A000F800000000; if64.b = 64'h004002C0C200FC00;
    if8.a  = 8'hFF;               if8.b  = 8'h01;
    if6.a  = 6'h3F;               if6.b  = 6'h3F;
    tick();
    check("v64_nocarry",  if64.sum, 129'h0_06E003B8C200FC00);
    check("v8_ff_01",     if8.sum,  129'h100);
    check("v6_3f_3f",     if6.sum,  129'h7E);

    if64.a = 64'h004002C0C200FC00; if64.b = 64'h0000016BA0366000;
    if8.a  = 8'hFF;               if8.b  = 8'hFF;
    if6.a  = 6'h15;               if6.b  = 6'h2A;
    tick();
    check("v64_chain",    if64.sum, 129'h0_0040042C62375C00);
    check("v8_ff_ff",     if8.sum,  129'h1FE);
    check("v6_15_2a",     if6.sum,  129'h3F);

    if64.a = 64'hFFFFFFFFFFFFFFFF; if64.b = 64'h1;
    tick();
    check("v64_fullprop", if64.sum, 129'h1_0000000000000000);

    if64.a = '1; if64.b = '1;
    tick();
    check("v64_allones",  if64.sum, 129'h1_FFFFFFFFFFFFFFFE);

    // Asynchronous reset mid-stream, between edges.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_64", if64.sum, 129'h0);
    check("async_rst_8",  if8.sum,  129'h0);
    tick();
    check("rst_still_64", if64.sum, 129'h0);

    if64.a = 64'hFFFFFFFFFFFFFFFF; if64.b = 64'h1;
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_64",  if64.sum, 129'h1_0000000000000000);

    if64.a = '0; if64.b = '0;
    tick();
    check("v64_zero",     if64.sum, 129'h0);

    // Partial-group width with random operands.
    for (int unsigned i = 0; i < 1000; i++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      if6.a = ra;
      if6.b = rb;
      rexp = {1'b0, ra} + {1'b0, rb};
      tick();
      check("v6_random",  if6.sum,  {122'h0, rexp});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
